// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
package mem_stage_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int REG_IDX_W  = 3;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RETIRE = 2'd2
    } state_e;

    // Word accesses only: any set low address bit is a misalignment.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return (addr_lo & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the LIMIT-th enabled cycle occurs.
module mem_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = en && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory stage: one instruction in flight, req/ack data-memory access, registered
// writeback packet. Define MEM_STAGE_TIMEOUT_EN to abort stalled accesses.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [DATA_W-1:0]    ex_result,
    input  logic [REG_IDX_W-1:0] ex_dest,
    input  logic                 ex_w_enable,
    input  logic                 ex_is_load,
    input  logic                 ex_is_store,
    input  logic [ADDR_W-1:0]    ex_addr,
    input  logic [DATA_W-1:0]    ex_store_data,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_W-1:0]    dmem_addr,
    output logic [DATA_W-1:0]    dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [DATA_W-1:0]    dmem_rdata,
    output logic                 wb_valid,
    output logic                 wb_we,
    output logic [REG_IDX_W-1:0] wb_dest,
    output logic [DATA_W-1:0]    wb_value,
    output logic                 exc_misalign,
    output logic                 bus_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mem_stage: TIMEOUT_CYCLES must be at least 1");
    end

    state_e                 state_q;
    logic                   dmem_req_q;
    logic                   dmem_we_q;
    logic [ADDR_W-1:0]      dmem_addr_q;
    logic [DATA_W-1:0]      dmem_wdata_q;
    logic                   wb_valid_q;
    logic                   wb_we_q;
    logic [REG_IDX_W-1:0]   wb_dest_q;
    logic [DATA_W-1:0]      wb_value_q;
    logic                   exc_q;
    logic                   bus_err_q;
    logic                   ld_q;
    logic                   wen_q;

    logic                   mem_op;
    logic                   misalign;
    logic                   timeout_expire;

    assign ex_ready = (state_q == ST_IDLE);
    assign mem_op   = ex_is_load | ex_is_store;
    assign misalign = is_misaligned(ex_addr[1:0]);

`ifdef MEM_STAGE_TIMEOUT_EN
    mem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q != ST_ACCESS),
        .en     ((state_q == ST_ACCESS) && !dmem_ack),
        .expire (timeout_expire)
    );
`else
    assign timeout_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_dest_q    <= '0;
            wb_value_q   <= '0;
            exc_q        <= 1'b0;
            bus_err_q    <= 1'b0;
            ld_q         <= 1'b0;
            wen_q        <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            exc_q      <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ex_valid) begin
                        wb_dest_q <= ex_dest;
                        if (!mem_op) begin
                            state_q    <= ST_RETIRE;
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= ex_w_enable;
                            wb_value_q <= ex_result;
                        end else if (misalign) begin
                            state_q    <= ST_RETIRE;
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= 1'b0;
                            exc_q      <= 1'b1;
                        end else begin
                            // A combined load+store request is executed as a load.
                            state_q      <= ST_ACCESS;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= ex_is_store & ~ex_is_load;
                            dmem_addr_q  <= ex_addr;
                            dmem_wdata_q <= ex_store_data;
                            ld_q         <= ex_is_load;
                            wen_q        <= ex_w_enable;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        state_q    <= ST_RETIRE;
                        dmem_req_q <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= ld_q & wen_q;
                        if (ld_q) begin
                            wb_value_q <= dmem_rdata;
                        end
                    end else if (timeout_expire) begin
                        state_q    <= ST_RETIRE;
                        dmem_req_q <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= 1'b0;
                        bus_err_q  <= 1'b1;
                    end
                end
                ST_RETIRE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_we        = wb_we_q;
    assign wb_dest      = wb_dest_q;
    assign wb_value     = wb_value_q;
    assign exc_misalign = exc_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writebacks and memory
// requests; a memory responder and a writeback monitor pop and compare.
module tb_mem_stage;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 16;
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0]  dest;
        logic        we;
        logic [31:0] value;
        logic        chk_val;
        logic        exc;
        logic        berr;
        int          due;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_exp_t;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic [2:0]  ex_dest;
    logic        ex_w_enable;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [2:0]  wb_dest;
    logic [31:0] wb_value;
    logic        exc_misalign;
    logic        bus_err;

    wb_exp_t     wb_q[$];
    req_exp_t    req_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dev_mem [logic [31:0]];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int cur_lat  = 0;
    int late_req = 0;

    mem_stage #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_result     (ex_result),
        .ex_dest       (ex_dest),
        .ex_w_enable   (ex_w_enable),
        .ex_is_load    (ex_is_load),
        .ex_is_store   (ex_is_store),
        .ex_addr       (ex_addr),
        .ex_store_data (ex_store_data),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ack      (dmem_ack),
        .dmem_rdata    (dmem_rdata),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_dest       (wb_dest),
        .wb_value      (wb_value),
        .exc_misalign  (exc_misalign),
        .bus_err       (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Initial memory image shared by the device model and the reference.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        if (dev_mem.exists(a)) return dev_mem[a];
        return init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_idle();
        ex_valid      = 1'b0;
        ex_result     = $urandom;
        ex_dest       = 3'($urandom);
        ex_w_enable   = 1'($urandom);
        ex_is_load    = 1'($urandom);
        ex_is_store   = 1'($urandom);
        ex_addr       = $urandom;
        ex_store_data = $urandom;
    endtask

    // Issue one instruction (caller is at posedge+1). lat = req cycles without
    // ack before the ack cycle; negative means memory never acks.
    task automatic send(input logic ld, input logic st, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] res,
                        input logic [2:0] dest, input logic wen, input int lat);
        int      n = 0;
        int      due_off = 0;
        bit      push = 1'b1;
        logic    mem_op, mis, eff_st;
        wb_exp_t e;
        while (!ex_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ex_ready_wait", ex_ready, 1);
        cur_lat       = lat;
        ex_valid      = 1'b1;
        ex_is_load    = ld;
        ex_is_store   = st;
        ex_addr       = addr;
        ex_store_data = data;
        ex_result     = res;
        ex_dest       = dest;
        ex_w_enable   = wen;

        mem_op    = ld | st;
        mis       = mem_op && (addr[1:0] != 2'b00);
        eff_st    = st & ~ld;
        e.dest    = dest;
        e.we      = wen;
        e.value   = res;
        e.chk_val = 1'b1;
        e.exc     = mis;
        e.berr    = 1'b0;
        if (mem_op) begin
            e.we      = 1'b0;
            e.chk_val = 1'b0;
            if (!mis) begin
                req_q.push_back('{we: eff_st, addr: addr, wdata: data});
                if (lat < 0) begin
                    e.berr  = 1'b1;
                    due_off = TO;
                    push    = TO_EN;
                end else begin
                    due_off = lat + 1;
                    if (eff_st) begin
                        ref_mem[addr] = data;
                    end else begin
                        e.we      = wen;
                        e.value   = ref_rd(addr);
                        e.chk_val = 1'b1;
                    end
                end
            end
        end
        @(posedge clk); #1;
        e.due = cyc + due_off;
        if (push) wb_q.push_back(e);
        chk("ex_ready_busy", ex_ready, 0);
        if (mis) chk("no_req_misalign", dmem_req, 0);
        drive_idle();
    endtask

    // Memory responder: checks request fields and their stability, acks after cur_lat cycles.
    initial begin
        int       cnt = 0;
        int       done = 0;
        req_exp_t cap;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        cap        = '{we: 1'b0, addr: 32'h0, wdata: 32'h0};
        forever begin
            @(negedge clk);
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            if (rst_n && dmem_req) begin
                if (cnt == 0) begin
                    if (req_q.size() == 0) begin
                        chk("unexpected_req", dmem_req, 0);
                        cap = '{we: dmem_we, addr: dmem_addr, wdata: dmem_wdata};
                    end else begin
                        cap = req_q.pop_front();
                        chk("req_we", dmem_we, cap.we);
                        chk("req_addr", dmem_addr, cap.addr);
                        if (cap.we) chk("req_wdata", dmem_wdata, cap.wdata);
                    end
                end else begin
                    chk("req_hold_we", dmem_we, cap.we);
                    chk("req_hold_addr", dmem_addr, cap.addr);
                    if (cap.we) chk("req_hold_wdata", dmem_wdata, cap.wdata);
                end
                cnt++;
                if (cur_lat >= 0 && cnt == cur_lat + 1) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) dev_mem[dmem_addr] = dmem_wdata;
                    else         dmem_rdata = dev_rd(dmem_addr);
                end
            end else begin
                cnt = 0;
            end
            if (late_req != done) begin
                dmem_ack = 1'b1;
                done     = late_req;
            end
        end
    end

    // Writeback monitor.
    initial begin
        logic    prev = 1'b0;
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (!wb_valid) begin
                    chk("pulse_without_wb", {30'h0, exc_misalign, bus_err}, 0);
                end else begin
                    chk("wb_pulse_len", prev, 0);
                    if (wb_q.size() == 0) begin
                        chk("unexpected_wb", wb_valid, 0);
                    end else begin
                        e = wb_q.pop_front();
                        chk("wb_cycle", 32'(cyc), 32'(e.due));
                        chk("wb_dest", wb_dest, e.dest);
                        chk("wb_we", wb_we, e.we);
                        if (e.chk_val) chk("wb_value", wb_value, e.value);
                        chk("exc_misalign", exc_misalign, e.exc);
                        chk("bus_err", bus_err, e.berr);
                    end
                end
                prev = wb_valid;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          kind, lat;
        logic [31:0] a;
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_dest", wb_dest, 0);
        chk("rst_wb_value", wb_value, 0);
        chk("rst_exc", exc_misalign, 0);
        chk("rst_bus_err", bus_err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", ex_ready, 1);

        send(1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_1234, 3'd3, 1'b1, 0);
        send(1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 3'd5, 1'b1, 3);
        send(1'b0, 1'b1, 32'h80, 32'hA5A5_A5A5, 32'h0, 3'd0, 1'b0, 0);
        send(1'b1, 1'b0, 32'h42, 32'h0, 32'h0, 3'd6, 1'b1, 0);
        send(1'b0, 1'b1, 32'h83, 32'h1111_2222, 32'h0, 3'd1, 1'b1, 0);
        send(1'b1, 1'b1, 32'h80, 32'hFFFF_0000, 32'h0, 3'd7, 1'b1, 1);
        send(1'b1, 1'b0, 32'h80, 32'h0, 32'h0, 3'd2, 1'b0, 2);

        for (int i = 0; i < 120; i++) begin
            kind = $urandom_range(0, 9);
            lat  = TO_EN ? $urandom_range(0, TO - 1) : $urandom_range(0, 5);
            a    = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            if (kind == 8) a = a + 32'($urandom_range(1, 3));
            case (kind)
                0, 1, 2: send(1'b0, 1'b0, $urandom, $urandom, $urandom, 3'($urandom), 1'($urandom), 0);
                3, 4, 5: send(1'b1, 1'b0, a, $urandom, $urandom, 3'($urandom), 1'($urandom), lat);
                6, 7:    send(1'b0, 1'b1, a, $urandom, $urandom, 3'($urandom), 1'($urandom), lat);
                8:       send(1'($urandom), 1'b1, a, $urandom, $urandom, 3'($urandom), 1'b1, lat);
                default: send(1'b1, 1'b1, a, $urandom, $urandom, 3'($urandom), 1'b1, lat);
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

`ifdef MEM_STAGE_TIMEOUT_EN
        send(1'b0, 1'b1, 32'h200, 32'h0BAD_F00D, 32'h0, 3'd4, 1'b1, -1);
        send(1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 3'd4, 1'b1, TO - 1);
        send(1'b1, 1'b0, 32'h204, 32'h0, 32'h0, 3'd6, 1'b1, -1);
`endif

        // Reset while a load is waiting for its ack.
        send(1'b1, 1'b0, 32'h44, 32'h0, 32'h0, 3'd2, 1'b1, -1);
        @(posedge clk); #1;
        chk("req_before_reset", dmem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("req_dropped_on_reset", dmem_req, 0);
        chk("no_wb_on_reset", wb_valid, 0);
        wb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        late_req = late_req + 1;
        repeat (3) @(posedge clk);
        #1;
        chk("ready_after_mid_reset", ex_ready, 1);
        chk("req_idle_after_reset", dmem_req, 0);
        send(1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFE_0001, 3'd1, 1'b1, 0);

        repeat (10) @(posedge clk);
        #1;
        chk("pending_wb", 32'(wb_q.size()), 0);
        chk("pending_req", 32'(req_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of execute; consumes the execute result, destination register, write enable and the load/store request.
- Performs the data-memory access through a req/ack handshake with variable-latency memory.
- Presents a registered writeback packet (valid, dest, value, write enable) to the register file.
- Back-pressures execute while a memory access is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, data word width.
- TIMEOUT_CYCLES, 16, cycles to wait for dmem_ack before abort. Used only with MEM_STAGE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute presents an instruction.
- ex_ready  out  1  stage accepts instruction this cycle.
- ex_result  in  DATA_W  execute result (ALU/MOV value).
- ex_dest  in  3  destination register index.
- ex_w_enable  in  1  instruction writes the register file.
- ex_is_load  in  1  load operation.
- ex_is_store  in  1  store operation.
- ex_addr  in  ADDR_W  effective address (base + immediate).
- ex_store_data  in  DATA_W  store value.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  ADDR_W  request address.
- dmem_wdata  out  DATA_W  write data.
- dmem_ack  in  1  memory completes request; dmem_rdata valid this cycle for reads.
- dmem_rdata  in  DATA_W  read data.
- wb_valid  out  1  one-cycle retire pulse.
- wb_we  out  1  register write enable (qualified by wb_valid).
- wb_dest  out  3  register index.
- wb_value  out  DATA_W  write value.
- exc_misalign  out  1  one-cycle pulse: misaligned access retired.
- bus_err  out  1  one-cycle pulse: access timed out (0 without feature).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - dmem_req, dmem_we, wb_valid, wb_we, exc_misalign, bus_err = 0.
  - dmem_addr, dmem_wdata, wb_dest, wb_value = 0.
  - ex_ready follows state, so it reads 1 once reset deasserts.
- States: IDLE, ACCESS, RETIRE.
- ex_ready = (state==IDLE). It is combinational from state only, never from ex_valid.
- Accept condition: ex_valid & ex_ready at a rising edge.
  - Non-memory op: go to RETIRE. Next cycle wb_valid=1, wb_value=ex_result, wb_we=ex_w_enable. Latency 1.
  - Load/store, ex_addr[1:0]==0: go to ACCESS. dmem_req=1 from the next cycle, with dmem_addr, dmem_we (=store), dmem_wdata registered.
  - Load/store, ex_addr[1:0]!=0: no request issued. Go to RETIRE with wb_we=0 and exc_misalign=1 for the retire cycle.
  - ex_is_load and ex_is_store both set: treated as load; store ignored.
- ACCESS:
  - dmem_req and all dmem_* outputs are held stable until dmem_ack.
  - On the ack edge: dmem_req drops next cycle, and the next state is RETIRE.
  - Load: wb_value = dmem_rdata captured on the ack edge; wb_we = ex_w_enable as latched at accept.
  - Store: wb_we=0.
  - Minimum load/store latency: accept edge N, req high cycle N+1, ack same cycle, wb_valid cycle N+2.
- RETIRE:
  - wb_valid=1 for exactly one cycle; return to IDLE.
  - No new accept in RETIRE, so at most one instruction is ever in flight.
- dmem_ack while not in ACCESS: ignored.
- Reset asserted mid-ACCESS: request withdrawn immediately and the in-flight instruction is dropped (no wb_valid). A late ack after reset is ignored.
- ex_* inputs are don't-care when ex_valid=0 or ex_ready=0.

Optional Feature:
- MEM_STAGE_TIMEOUT_EN defined:
  - A cycle counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop dmem_req, go to RETIRE with wb_we=0, and pulse bus_err with wb_valid.
  - Ack on the same cycle as the limit wins (normal completion).
- Not defined: ACCESS waits indefinitely; bus_err tied 0; no counter logic.

Decomposition:
- mem_stage_pkg:
  - state enum (IDLE/ACCESS/RETIRE).
  - REG_IDX_W=3.
  - ALIGN_MASK=2'b11.
  - default DATA_W/ADDR_W constants.
- One sub-module, mem_timeout_ctr: clear/enable/expire counter, instantiated only under MEM_STAGE_TIMEOUT_EN. All other logic is inline.

Test Plan:
- ALU op: ex_result=0x0000_1234, dest=3, w_enable=1, accepted cycle 0 -> wb_valid=1, wb_we=1, wb_dest=3, wb_value=0x1234 at cycle 1; ex_ready=0 at cycle 1.
- Load: addr=0x40, dest=5; memory acks 3 cycles after req with rdata=0xDEAD_BEEF -> dmem_req/addr held stable 3 cycles, then wb_value=0xDEADBEEF, wb_we=1 one cycle after ack.
- Store: addr=0x80, data=0xA5A5_A5A5; ack in first req cycle -> dmem_we=1, wdata correct, wb_valid=1 with wb_we=0 at accept+2.
- Misaligned load: addr=0x42 -> dmem_req never asserts; wb_valid=1, wb_we=0, exc_misalign=1 at cycle 1.
- Reset mid-ACCESS: rst_n low 2 cycles while req pending, then ack arrives -> dmem_req=0 immediately, no wb_valid, ex_ready=1 after reset.
- With MEM_STAGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never returns -> req high exactly 4 cycles, then bus_err=1 and wb_valid=1 with wb_we=0.
